// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   - tx_state_e      : transmit FSM state encoding
//   - BAUD_*          : baud-select codes 0..7 shared with the baud generator
//   - FRAME_BITS_*    : frame lengths in bit times (start + data + parity + stop)
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;
    localparam logic [2:0] BAUD_230400 = 3'd5;
    localparam logic [2:0] BAUD_460800 = 3'd6;
    localparam logic [2:0] BAUD_921600 = 3'd7;

    localparam int FRAME_BITS_1STOP     = 10;
    localparam int FRAME_BITS_2STOP     = 11;
    localparam int FRAME_BITS_PAR_1STOP = 11;
    localparam int FRAME_BITS_PAR_2STOP = 12;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO holding bytes awaiting transmission.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset (pointers/count only)
//   push, din     write request and data (ignored when full)
//   pop, dout     read request and head-of-queue data (dout is combinational)
//   full, empty   occupancy flags derived from the registered count
//   count         current occupancy, 0..DEPTH
module uart_tx_fifo #(
    parameter  int DEPTH = 8,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmitter. Buffers bytes in a FIFO and serialises them
// LSB-first: start bit, 8 data bits, optional parity, 1 or 2 stop bits.
// One bit time is one period of uart_clk_i; all FSM moves happen on its rising edge.
// Optional feature: define UART_TX_PARITY_EN to add parity_odd_i and the parity bit.
// Ports:
//   clk_i, rst_i   system clock, asynchronous active-high reset
//   uart_clk_i     baud square wave, already synchronous to clk_i
//   tx_data_i/tx_valid_i/tx_ready_o  byte push handshake (ready = FIFO not full)
//   stop2_i        two stop bits when 1, latched at frame start
//   parity_odd_i   odd parity when 1 (UART_TX_PARITY_EN only), latched at frame start
//   tx_o           registered serial line, idle high
//   busy_o         frame in progress or bytes queued
//   tx_done_o      one-clk pulse when the final stop bit ends
//   fifo_count_o   FIFO occupancy
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter  int FIFO_DEPTH = 8,
    parameter  int DATA_W     = 8,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1,
    localparam int BW         = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              uart_clk_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic              stop2_i,
`ifdef UART_TX_PARITY_EN
    input  logic              parity_odd_i,
`endif
    output logic              tx_o,
    output logic              busy_o,
    output logic              tx_done_o,
    output logic [CW-1:0]     fifo_count_o
);

    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    tx_state_e         state, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              stop2_q, stop2_d;
    logic              stop_sec_q, stop_sec_d;   // second stop bit in progress
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              uart_clk_q;
    logic              tick;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign tick         = uart_clk_i & ~uart_clk_q;
    assign tx_ready_o   = ~fifo_full;
    assign busy_o       = (state != ST_IDLE) | ~fifo_empty;
    assign tx_o         = tx_q;
    assign tx_done_o    = done_q;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (tx_valid_i & ~fifo_full),
        .pop   (pop),
        .din   (tx_data_i),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_o)
    );

    // tx_d is the line level for the state being entered, so the line is a
    // flop and changes exactly on the tick edge.
    always_comb begin
        state_d    = state;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop2_d    = stop2_q;
        stop_sec_d = stop_sec_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) pop = 1'b1;
                end
                ST_START: begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
                ST_DATA: begin
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
                ST_PARITY: begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
                ST_STOP: begin
                    if (stop2_q && !stop_sec_q) begin
                        stop_sec_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                        // chain straight into the next frame with no idle bit
                        if (!fifo_empty) pop = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            endcase
            // frame start: load byte and latch this frame's configuration
            if (pop) begin
                state_d    = ST_START;
                tx_d       = 1'b0;
                shift_d    = fifo_dout;
                stop2_d    = stop2_i;
                stop_sec_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                par_d      = ^fifo_dout ^ parity_odd_i;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop2_q    <= 1'b0;
            stop_sec_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            uart_clk_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop2_q    <= stop2_d;
            stop_sec_q <= stop_sec_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            uart_clk_q <= uart_clk_i;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule
